// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
// Constants shared by the instruction loader and its byte assembler:
//   - BYTE_W    : width of one received byte
//   - HALT_WORD : instruction word that terminates a load (it is still written)
//   - ST_*      : 2-bit FSM state encoding of the loader
// -----------------------------------------------------------------------------
package instr_loader_pkg;

  localparam int          BYTE_W    = 8;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs incoming bytes, first byte = MSB, into a B-bit word.
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset, clears bytes and counter
//   clear_i      : synchronous clear, discards any partial word (wins over capture)
//   capture_i    : accept byte_i this cycle
//   byte_i       : byte to accept
//   word_o       : word formed by the held bytes followed by byte_i
//   word_ready_o : high when the byte being captured completes a word
// -----------------------------------------------------------------------------
module word_assembler
  import instr_loader_pkg::*;
#(
  parameter int B = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              capture_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [B-1:0]      word_o,
  output logic              word_ready_o
);

  // Only the three earlier bytes need storage; the fourth is taken straight
  // from byte_i when the word completes.
  logic [B-BYTE_W-1:0] shift_q, shift_d;
  logic [1:0]          cnt_q, cnt_d;

  assign word_o       = {shift_q, byte_i};
  assign word_ready_o = capture_i && !clear_i && (cnt_q == 2'd3);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = 2'd0;
    end else if (capture_i) begin
      shift_d = word_o[B-BYTE_W-1:0];
      cnt_d   = cnt_q + 2'd1;   // wraps to 0 after the fourth byte
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Debug-path loader: packs a UART byte stream into 32-bit instructions and
// writes them to instruction memory at byte addresses 0,4,8,... until the HALT
// word has been written or memory is full, then holds a sticky done flag.
// Ports:
//   i_clk     : clock, rising edge
//   i_reset   : asynchronous active-low reset
//   i_start   : single-cycle start pulse (honoured in IDLE and DONE only)
//   i_rx_data : received byte, valid while i_rx_done is high
//   i_rx_done : one-cycle byte strobe
//   o_write   : one-cycle memory write enable per word
//   o_addr    : byte address of the write (multiple of 4)
//   o_data    : instruction word to write
//   o_busy    : high while receiving or writing
//   o_done    : sticky load-complete flag
//   o_count   : words written in the current or last load
// -----------------------------------------------------------------------------
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int B  = 32,
  parameter int W  = 5,
  parameter int PC = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_done,
  output logic          o_write,
  output logic [PC-1:0] o_addr,
  output logic [B-1:0]  o_data,
  output logic          o_busy,
  output logic          o_done,
  output logic [W:0]    o_count
);

  localparam logic [W:0]    CNT_ONE   = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]    CNT_FULL  = {1'b1, {W{1'b0}}};
  localparam logic [PC-1:0] ADDR_STEP = PC'(4);

  logic [1:0]    state_q, state_d;
  logic [PC-1:0] addr_q, addr_d;
  logic [W:0]    count_q, count_d;
  logic [B-1:0]  data_q, data_d;

  logic          asm_clear;
  logic          asm_capture;
  logic [B-1:0]  asm_word;
  logic          asm_ready;
  logic [W:0]    count_inc;

  word_assembler #(.B(B)) u_asm (
    .clk_i        (i_clk),
    .rst_ni       (i_reset),
    .clear_i      (asm_clear),
    .capture_i    (asm_capture),
    .byte_i       (i_rx_data),
    .word_o       (asm_word),
    .word_ready_o (asm_ready)
  );

  assign count_inc = count_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    data_d      = data_q;
    asm_clear   = 1'b0;
    asm_capture = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d   = ST_RECV;
          addr_d    = '0;
          count_d   = '0;
          asm_clear = 1'b1;
        end
      end
      ST_RECV: begin
        asm_capture = i_rx_done;
        if (asm_ready) begin
          // Latch the finished word separately so the assembler can already
          // take the next byte while this one is on o_data.
          data_d  = asm_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_STEP;
        count_d = count_inc;
        if ((data_q == HALT_WORD) || (count_inc == CNT_FULL)) begin
          state_d   = ST_DONE;
          asm_clear = 1'b1;          // a byte arriving now is dropped
        end else begin
          state_d     = ST_RECV;
          asm_capture = i_rx_done;   // becomes byte 0 of the next word
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  // Outputs are decodes of registers only; no input reaches them combinationally.
  assign o_write = (state_q == ST_WRITE);
  assign o_busy  = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign o_done  = (state_q == ST_DONE);
  assign o_addr  = addr_q;
  assign o_data  = data_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
// Randomized and directed byte streams against a word-level reference model;
// expected memory writes queue up as bytes are issued and a monitor compares
// every o_write pulse against the queue.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int          CAP  = 32;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_done = 1'b0;
  logic        o_write;
  logic [31:0] o_addr;
  logic [31:0] o_data;
  logic        o_busy;
  logic        o_done;
  logic [5:0]  o_count;

  instr_loader #(.B(32), .W(5), .PC(32)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_rx_data (i_rx_data),
    .i_rx_done (i_rx_done),
    .o_write   (o_write),
    .o_addr    (o_addr),
    .o_data    (o_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_count   (o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  compared = 0;
  int  mism     = 0;

  // Reference model: a load accepts bytes, every four make a word written at
  // the next address; the load ends with HALT or a full memory.
  bit          m_loading = 1'b0;
  bit          m_done    = 1'b0;
  logic [31:0] m_acc     = '0;
  int          m_nb      = 0;
  int          m_addr    = 0;
  int          m_cnt     = 0;

  task automatic model_byte(input logic [7:0] b);
    wr_t e;
    if (!m_loading) return;
    m_acc = {m_acc[23:0], b};
    m_nb++;
    if (m_nb == 4) begin
      e.addr = m_addr;
      e.data = m_acc;
      sb_q.push_back(e);
      m_addr += 4;
      m_cnt++;
      m_nb = 0;
      if (m_acc == HALT || m_cnt == CAP) begin
        m_loading = 1'b0;
        m_done    = 1'b1;
      end
    end
  endtask

  task automatic model_start();
    if (m_loading) return;
    m_loading = 1'b1;
    m_done    = 1'b0;
    m_addr    = 0;
    m_cnt     = 0;
    m_nb      = 0;
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_done    = 1'b0;
    m_addr    = 0;
    m_cnt     = 0;
    m_nb      = 0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge i_clk) begin
    wr_t e;
    if (i_reset === 1'b1 && o_write === 1'b1) begin
      compared++;
      if (sb_q.size() == 0) begin
        mism++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", o_addr, o_data);
      end else begin
        e = sb_q.pop_front();
        if (o_addr !== e.addr || o_data !== e.data) begin
          mism++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   o_addr, o_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_done = 1'b1;
    model_byte(b);
    tick();
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(t[31:24], int'($urandom_range(0, maxgap)));
      t = t << 8;
    end
  endtask

  task automatic do_start();
    repeat (2) tick();
    i_start = 1'b1;
    model_start();
    tick();
    i_start = 1'b0;
  endtask

  task automatic check_status(input string nm);
    repeat (2) tick();
    chk({nm, "_done"},  {63'd0, o_done}, {63'd0, m_done});
    chk({nm, "_busy"},  {63'd0, o_busy}, {63'd0, m_loading});
    chk({nm, "_count"}, {58'd0, o_count}, 64'(m_cnt));
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_write"}, {63'd0, o_write}, 64'd0);
    chk({nm, "_addr"},  {32'd0, o_addr},  64'd0);
    chk({nm, "_data"},  {32'd0, o_data},  64'd0);
    chk({nm, "_busy"},  {63'd0, o_busy},  64'd0);
    chk({nm, "_done"},  {63'd0, o_done},  64'd0);
    chk({nm, "_count"}, {58'd0, o_count}, 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    int          nw;

    // Reset state
    #2;
    check_all_zero("reset");
    repeat (2) tick();
    i_reset = 1'b1;
    tick();

    // Bytes in IDLE are ignored
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0);
    check_status("idle_ignore");

    // Basic load
    do_start();
    chk("busy_after_start", {63'd0, o_busy}, 64'd1);
    send_word(32'h2008_0005, 2);
    send_word(HALT, 2);
    check_status("basic");

    // Bytes in DONE are ignored
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1);
    check_status("done_ignore");

    // Restart from DONE
    do_start();
    send_word(32'h0000_0000, 1);
    send_word(HALT, 1);
    check_status("restart");

    // Capacity with an ignored start pulse mid-word
    do_start();
    for (int n = 0; n < CAP; n++) begin
      w = $urandom;
      if (w == HALT) w = 32'h0;
      if (n == 5) begin
        send_byte(w[31:24], 0);
        send_byte(w[23:16], 0);
        i_start = 1'b1;
        model_start();
        tick();
        i_start = 1'b0;
        send_byte(w[15:8], 1);
        send_byte(w[7:0], 0);
      end else begin
        send_word(w, 1);
      end
    end
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0);
    check_status("capacity");

    // Strobe in the WRITE cycle becomes byte 0 of the next word
    do_start();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'hAA, 2);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 2);
    send_word(HALT, 0);
    send_byte(8'h55, 0);   // lands in the HALT write cycle and is dropped
    check_status("write_strobe");

    // Reset mid-word
    do_start();
    send_word(32'h1234_5678, 1);
    send_byte(8'h9A, 0);
    send_byte(8'hBC, 1);
    i_reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("mid_reset");
    tick();
    i_reset = 1'b1;
    tick();
    do_start();
    send_word(32'hCAFE_F00D, 0);
    send_word(HALT, 0);
    check_status("after_reset");

    // Randomized loads
    for (int l = 0; l < 5; l++) begin
      do_start();
      nw = int'($urandom_range(1, 8));
      for (int n = 0; n < nw; n++) begin
        w = $urandom;
        if (w == HALT) w = 32'h0;
        if (n == nw - 1) w = HALT;
        send_word(w, 2);
      end
      for (int k = 0; k < int'($urandom_range(0, 4)); k++)
        send_byte(8'($urandom), int'($urandom_range(0, 1)));
      check_status("random");
    end

    repeat (3) tick();
    chk("pending_writes", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
